// File: rtl/pll_reset_sequencer.sv
// Synchronises the raw PLL lock flag, qualifies it for a programmable time and
// releases a sequenced reset; re-asserts reset and logs events on loss of lock.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_W              = 8
) (
    input  logic             clk_13_mhz,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             sw_reset_req,
    output logic             sys_rst,
    output logic             sys_ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lock_lost_cnt,
    output logic [1:0]       seq_state
);

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CTR_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
    localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CTR_W-1:0] HOLD_LAST   = CTR_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CTR_W-1:0] CTR_ZERO    = CTR_W'(1'b0);
    localparam logic [CTR_W-1:0] CTR_ONE     = CTR_W'(1'b1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_HOLD_RST  = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;
    seq_state_e             state_r;
    seq_state_e             state_nxt_s;
    logic [CTR_W-1:0]       ctr_r;
    logic [CTR_W-1:0]       ctr_nxt_s;
    logic                   sys_rst_r;
    logic                   sys_ready_r;
    logic                   lock_lost_r;
    logic                   lock_lost_nxt_s;
    logic [CNT_W-1:0]       lost_cnt_r;
    logic [CNT_W-1:0]       lost_cnt_nxt_s;

    // Saturating increment so the diagnostic count never wraps back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_W'(1'b1);
        end
        return result;
    endfunction

    // Lock flag synchroniser; the only consumer of the raw pll_locked input.
    always_ff @(posedge clk_13_mhz) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_r[SYNC_STAGES-1];

    // Next-state, counter and diagnostic logic; lock loss is tested first in every state.
    always_comb begin
        state_nxt_s     = state_r;
        ctr_nxt_s       = ctr_r;
        lock_lost_nxt_s = lock_lost_r;
        lost_cnt_nxt_s  = lost_cnt_r;
        case (state_r)
            ST_WAIT_LOCK: begin
                ctr_nxt_s = CTR_ZERO;
                if (locked_s) begin
                    state_nxt_s = ST_STABILIZE;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                    ctr_nxt_s   = CTR_ZERO;
                end else if (ctr_r == STABLE_LAST) begin
                    state_nxt_s = ST_HOLD_RST;
                    ctr_nxt_s   = CTR_ZERO;
                end else begin
                    ctr_nxt_s = ctr_r + CTR_ONE;
                end
            end
            ST_HOLD_RST: begin
                if (!locked_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                    ctr_nxt_s   = CTR_ZERO;
                end else if (sw_reset_req) begin
                    ctr_nxt_s = CTR_ZERO;
                end else if (ctr_r == HOLD_LAST) begin
                    state_nxt_s = ST_RUN;
                    ctr_nxt_s   = CTR_ZERO;
                end else begin
                    ctr_nxt_s = ctr_r + CTR_ONE;
                end
            end
            ST_RUN: begin
                ctr_nxt_s = CTR_ZERO;
                if (!locked_s) begin
                    state_nxt_s     = ST_WAIT_LOCK;
                    lock_lost_nxt_s = 1'b1;
                    lost_cnt_nxt_s  = sat_inc(lost_cnt_r);
                end else if (sw_reset_req) begin
                    state_nxt_s = ST_HOLD_RST;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_LOCK;
                ctr_nxt_s   = CTR_ZERO;
            end
        endcase
    end

    // State, counter and outputs; outputs are registered from the next state so they track state_r.
    always_ff @(posedge clk_13_mhz) begin
        if (rst) begin
            state_r     <= ST_WAIT_LOCK;
            ctr_r       <= CTR_ZERO;
            sys_rst_r   <= 1'b1;
            sys_ready_r <= 1'b0;
            lock_lost_r <= 1'b0;
            lost_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            ctr_r       <= ctr_nxt_s;
            sys_rst_r   <= (state_nxt_s != ST_RUN);
            sys_ready_r <= (state_nxt_s == ST_RUN);
            lock_lost_r <= lock_lost_nxt_s;
            lost_cnt_r  <= lost_cnt_nxt_s;
        end
    end

    assign sys_rst       = sys_rst_r;
    assign sys_ready     = sys_ready_r;
    assign lock_lost     = lock_lost_r;
    assign lock_lost_cnt = lost_cnt_r;
    assign seq_state     = state_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output vectors are queued
// per clock as stimulus is applied and compared after the following edge.
module tb_pll_reset_sequencer;

    logic       clk_13_mhz = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       sys_rst;
    logic       sys_ready;
    logic       lock_lost;
    logic [1:0] lock_lost_cnt;
    logic [1:0] seq_state;

    logic [6:0] obs_s;
    logic [6:0] exp_v;
    logic [6:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES(2),
        .LOCK_STABLE_CYCLES(8),
        .RESET_HOLD_CYCLES(4),
        .CNT_W(2)
    ) dut (
        .clk_13_mhz(clk_13_mhz),
        .rst(rst),
        .pll_locked(pll_locked),
        .sw_reset_req(sw_reset_req),
        .sys_rst(sys_rst),
        .sys_ready(sys_ready),
        .lock_lost(lock_lost),
        .lock_lost_cnt(lock_lost_cnt),
        .seq_state(seq_state)
    );

    always #5 clk_13_mhz = ~clk_13_mhz;

    // Observed vector: {state, sys_rst, sys_ready, lock_lost, count}
    assign obs_s = {seq_state, sys_rst, sys_ready, lock_lost, lock_lost_cnt};

    function automatic logic [6:0] mk(input int st, input logic ll, input int c);
        logic [1:0] s2;
        logic [1:0] c2;
        s2 = 2'(st);
        c2 = 2'(c);
        return {s2, (st != 3), (st == 3), ll, c2};
    endfunction

    // State after edge j when lock has been steady since edge 0 (edge 0 first samples 1).
    function automatic int qual_state(input int j);
        if (j < 2)       return 0;
        else if (j < 10) return 1;
        else if (j < 14) return 2;
        else             return 3;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 19; i++) begin
            rst = (i < 3);
            pll_locked = (i >= 3);
            sw_reset_req = 1'b0;
            exp_q.push_back((i < 3) ? mk(0, 1'b0, 0) : mk(qual_state(i - 3), 1'b0, 0));
            @(posedge clk_13_mhz);
            @(negedge clk_13_mhz);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL power_up[%0d]: got %b want %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_stab_loss();
        int j;
        for (int i = 0; i < 29; i++) begin
            rst = (i < 2);
            sw_reset_req = 1'b0;
            if (i < 2) begin
                pll_locked = 1'b0;
                exp_q.push_back(mk(0, 1'b0, 0));
            end else if (i < 14) begin
                j = i - 2;
                pll_locked = (j < 7);
                exp_q.push_back(mk((j < 2) ? 0 : ((j < 9) ? 1 : 0), 1'b0, 0));
            end else begin
                j = i - 14;
                pll_locked = 1'b1;
                sw_reset_req = (j == 1) || (j == 5);
                exp_q.push_back(mk(qual_state(j), 1'b0, 0));
            end
            @(posedge clk_13_mhz);
            @(negedge clk_13_mhz);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL stab_loss[%0d]: got %b want %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_run_loss();
        for (int k = 1; k <= 4; k++) begin
            for (int i = 0; i < 19; i++) begin
                rst = 1'b0;
                sw_reset_req = 1'b0;
                pll_locked = (i >= 4);
                if (i < 2)      exp_q.push_back(mk(3, (k > 1), sat3(k - 1)));
                else if (i < 4) exp_q.push_back(mk(0, 1'b1, sat3(k)));
                else            exp_q.push_back(mk(qual_state(i - 4), 1'b1, sat3(k)));
                @(posedge clk_13_mhz);
                @(negedge clk_13_mhz);
                exp_v = exp_q.pop_front();
                n_checks++;
                if (obs_s !== exp_v) begin
                    n_fail++;
                    $display("FAIL run_loss%0d[%0d]: got %b want %b", k, i, obs_s, exp_v);
                end
            end
        end
    endtask

    task automatic test_sw_run();
        for (int i = 0; i < 6; i++) begin
            pll_locked = 1'b1;
            sw_reset_req = (i == 0);
            exp_q.push_back(mk((i < 4) ? 2 : 3, 1'b1, 3));
            @(posedge clk_13_mhz);
            @(negedge clk_13_mhz);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL sw_run[%0d]: got %b want %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_sw_in_hold();
        for (int i = 0; i < 8; i++) begin
            pll_locked = 1'b1;
            sw_reset_req = (i == 0) || (i == 2);
            exp_q.push_back(mk((i < 6) ? 2 : 3, 1'b1, 3));
            @(posedge clk_13_mhz);
            @(negedge clk_13_mhz);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL sw_in_hold[%0d]: got %b want %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_sw_and_loss();
        for (int i = 0; i < 21; i++) begin
            rst = (i < 2);
            sw_reset_req = 1'b0;
            if (i < 2) begin
                pll_locked = 1'b1;
                exp_q.push_back(mk(0, 1'b0, 0));
            end else if (i < 17) begin
                pll_locked = 1'b1;
                exp_q.push_back(mk(qual_state(i - 2), 1'b0, 0));
            end else begin
                pll_locked = 1'b0;
                sw_reset_req = (i == 19);
                exp_q.push_back((i < 19) ? mk(3, 1'b0, 0) : mk(0, 1'b1, 1));
            end
            @(posedge clk_13_mhz);
            @(negedge clk_13_mhz);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL sw_and_loss[%0d]: got %b want %b", i, obs_s, exp_v);
            end
        end
        sw_reset_req = 1'b0;
    endtask

    task automatic test_rst_in_hold();
        for (int i = 0; i < 36; i++) begin
            rst = 1'b0;
            sw_reset_req = 1'b0;
            pll_locked = 1'b1;
            if (i < 15) begin
                exp_q.push_back(mk(qual_state(i), 1'b1, 1));
            end else if (i < 19) begin
                pll_locked = 1'b0;
                exp_q.push_back((i < 17) ? mk(3, 1'b1, 1) : mk(0, 1'b1, 2));
            end else if (i < 31) begin
                exp_q.push_back(mk(qual_state(i - 19), 1'b1, 2));
            end else if (i < 33) begin
                rst = 1'b1;
                exp_q.push_back(mk(0, 1'b0, 0));
            end else begin
                exp_q.push_back(mk(qual_state(i - 33), 1'b0, 0));
            end
            @(posedge clk_13_mhz);
            @(negedge clk_13_mhz);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs_s !== exp_v) begin
                n_fail++;
                $display("FAIL rst_in_hold[%0d]: got %b want %b", i, obs_s, exp_v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stab_loss();
        test_run_loss();
        test_sw_run();
        test_sw_in_hold();
        test_sw_and_loss();
        test_rst_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
